// File: rtl/lector_adc_pkg.sv
// Shared types and constants for the lector_adc SPI capture stage.
package lector_adc_pkg;

  localparam int BITS_TRAMA = 16;
  localparam int BITS_CERO  = 4;
  localparam int W_DEF      = BITS_TRAMA - BITS_CERO;
  localparam int DIV_DEF    = 4;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ESPERA   = 2'd1,
    TRANSFER = 2'd2,
    FIN      = 2'd3
  } estado_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int ancho_cnt(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lector_adc_if.sv
// Capture-stage bus: start strobe and serial pins on one side, parallel sample on the other.
interface lector_adc_if #(
  parameter int W = lector_adc_pkg::W_DEF
);
  logic         Iniciar;
  logic         MISO;
  logic         SCLK;
  logic         CS_n;
  logic [W-1:0] Dato;
  logic         Valido;
  logic         Ocupado;

  modport master (
    output Iniciar, MISO,
    input  SCLK, CS_n, Dato, Valido, Ocupado
  );

  modport slave (
    input  Iniciar, MISO,
    output SCLK, CS_n, Dato, Valido, Ocupado
  );
endinterface

// File: rtl/lector_adc_sclk.sv
// SCLK half-period generator: low half then high half, with edge and period-end strobes.
module generador_sclk
  import lector_adc_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic CLK,
  input  logic Reset,
  input  logic en_i,
  output logic sclk_o,
  output logic flanco_baj_o,
  output logic flanco_sub_o,
  output logic fin_periodo_o
);

  localparam int CW = ancho_cnt(2 * DIV);
  localparam logic [CW-1:0] MEDIO  = CW'(DIV);
  localparam logic [CW-1:0] ULTIMO = CW'(2 * DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sclk_o        = !(en_i && (cnt_q < MEDIO));
  assign flanco_baj_o  = en_i && (cnt_q == '0);
  assign flanco_sub_o  = en_i && (cnt_q == MEDIO);
  assign fin_periodo_o = en_i && (cnt_q == ULTIMO);

endmodule

// File: rtl/lector_adc.sv
// One SPI read frame per Iniciar strobe on an AD7476-class ADC; Dato held until the next frame.
// Optional build macro LECTOR_ADC_PROMEDIO_EN: Dato becomes the mean of the last four samples.
module lector_adc
  import lector_adc_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  lector_adc_if.slave bus
);

  localparam int EW = ancho_cnt(DIV);
  localparam int BW = $clog2(BITS_TRAMA);
  localparam logic [EW-1:0] ESP_ULT = EW'(DIV - 1);

  estado_e               state_q, state_d;
  logic [EW-1:0]         esp_q, esp_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [BITS_TRAMA-1:0] sh_q, sh_d;
  logic                  cs_n_q, sclk_q, ocupado_q, valido_q;
  logic [W-1:0]          dato_q;

  logic gen_en, gen_sclk, flanco_baj, flanco_sub, fin_periodo;
  logic fin_primero;

  assign gen_en = (state_q == TRANSFER);

  generador_sclk #(.DIV(DIV)) u_sclk (
    .CLK           (CLK),
    .Reset         (Reset),
    .en_i          (gen_en),
    .sclk_o        (gen_sclk),
    .flanco_baj_o  (flanco_baj),
    .flanco_sub_o  (flanco_sub),
    .fin_periodo_o (fin_periodo)
  );

  always_comb begin
    state_d   = state_q;
    esp_d     = '0;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      REPOSO: begin
        bit_cnt_d = '0;
        if (bus.Iniciar) state_d = ESPERA;
      end
      ESPERA: begin
        if (esp_q == ESP_ULT) state_d = TRANSFER;
        else                  esp_d   = esp_q + 1'b1;
      end
      TRANSFER: begin
        if (flanco_baj) bit_cnt_d = bit_cnt_q + 1'b1;
        // Sixteen falling edges wrap the counter back to zero: the last period just ended.
        if (fin_periodo && (bit_cnt_q == '0)) state_d = FIN;
      end
      FIN: begin
        if (esp_q == ESP_ULT) state_d = REPOSO;
        else                  esp_d   = esp_q + 1'b1;
      end
      default: state_d = REPOSO;
    endcase
  end

  always_comb begin
    sh_d = sh_q;
    if (flanco_sub) sh_d = BITS_TRAMA'({sh_q, bus.MISO});
  end

  assign fin_primero = (state_q == FIN) && (esp_q == '0);

  // Pin outputs are registered from the state, so they trail it by one cycle.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= REPOSO;
      esp_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      esp_q     <= esp_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      cs_n_q    <= !((state_q == ESPERA) || (state_q == TRANSFER));
      sclk_q    <= gen_sclk;
      ocupado_q <= (state_q != REPOSO);
    end
  end

`ifdef LECTOR_ADC_PROMEDIO_EN
  logic [W-1:0] hist_q [4];
  logic         pend_q;
  logic [W+1:0] suma;

  always_comb begin
    suma = (W+2)'(hist_q[0]) + (W+2)'(hist_q[1]) + (W+2)'(hist_q[2]) + (W+2)'(hist_q[3]);
  end

  // NOTE: the history is a small register array and is reset so the first averages start from zero.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      pend_q   <= 1'b0;
      valido_q <= 1'b0;
      dato_q   <= '0;
    end else begin
      pend_q   <= fin_primero;
      valido_q <= pend_q;
      if (fin_primero) begin
        hist_q[0] <= sh_q[W-1:0];
        for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
      end
      if (pend_q) dato_q <= suma[W+1:2];
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (Reset) begin
      valido_q <= 1'b0;
      dato_q   <= '0;
    end else begin
      valido_q <= fin_primero;
      if (fin_primero) dato_q <= sh_q[W-1:0];
    end
  end
`endif

  assign bus.CS_n    = cs_n_q;
  assign bus.SCLK    = sclk_q;
  assign bus.Ocupado = ocupado_q;
  assign bus.Valido  = valido_q;
  assign bus.Dato    = dato_q;

endmodule
